// File: rtl/xif_gpio_csr.sv
// Memory-mapped GPIO/CSR block for the xif split bus: OUT, synchronised IN, IRQ code capture.
// Per-bit edge interrupts (MASK/PEND/POL, irq_o) are built only when XIF_GPIO_CSR_EDGE_IRQ_EN is defined.
module xif_gpio_csr #(
    parameter logic [31:0]       BASE_ADDR   = 32'h80000000,
    parameter int                GPIO_W      = 32,
    parameter logic [GPIO_W-1:0] OUT_RESET   = '0,
    parameter int                IRQ_NUM_POW = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   bus_req_i,
    input  logic                   bus_we_i,
    input  logic [31:0]            bus_addr_bi,
    input  logic [3:0]             bus_be_bi,
    input  logic [31:0]            bus_wdata_bi,
    output logic                   bus_ack_o,
    output logic                   bus_resp_o,
    output logic [31:0]            bus_rdata_bo,
    input  logic [GPIO_W-1:0]      gpio_bi,
    output logic [GPIO_W-1:0]      gpio_bo,
    input  logic [IRQ_NUM_POW-1:0] irq_code_i,
    input  logic                   irq_ack_i,
    output logic                   irq_o
);

    logic                   hit;
    logic                   wr_en;
    logic                   rd_en;
    logic [2:0]             idx;
    logic [31:0]            lane_mask;
    logic [GPIO_W-1:0]      wmask;
    logic [GPIO_W-1:0]      wbits;
    logic [31:0]            rd_mux;
    logic [GPIO_W-1:0]      out_q;
    logic [GPIO_W-1:0]      s1_q;
    logic [GPIO_W-1:0]      s2_q;
    logic                   code_valid_q;
    logic [IRQ_NUM_POW-1:0] code_q;
    logic [GPIO_W-1:0]      mask_v;
    logic [GPIO_W-1:0]      pend_v;
    logic [GPIO_W-1:0]      pol_v;
    logic                   irq_v;
    logic                   unused_bits;

    assign hit       = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
    assign idx       = bus_addr_bi[4:2];
    assign wr_en     = bus_req_i & bus_we_i & hit;
    assign rd_en     = bus_req_i & ~bus_we_i;
    assign lane_mask = {{8{bus_be_bi[3]}}, {8{bus_be_bi[2]}}, {8{bus_be_bi[1]}}, {8{bus_be_bi[0]}}};
    assign wmask     = lane_mask[GPIO_W-1:0];
    assign wbits     = bus_wdata_bi[GPIO_W-1:0];
    assign bus_ack_o = bus_req_i;
    assign gpio_bo   = out_q;
    assign irq_o     = irq_v;
    assign unused_bits = ^{bus_addr_bi[1:0], bus_wdata_bi, lane_mask};

    function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_W-1:0] = v;
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= OUT_RESET;
            s1_q         <= '0;
            s2_q         <= '0;
            code_valid_q <= 1'b0;
            code_q       <= '0;
        end else begin
            s1_q <= gpio_bi;
            s2_q <= s1_q;
            if (wr_en && idx == 3'd0)
                out_q <= (out_q & ~wmask) | (wbits & wmask);
            // A fresh acknowledge beats the read-to-clear of the valid flag.
            if (irq_ack_i) begin
                code_valid_q <= 1'b1;
                code_q       <= irq_code_i;
            end else if (rd_en && hit && idx == 3'd5) begin
                code_valid_q <= 1'b0;
            end
        end
    end

`ifdef XIF_GPIO_CSR_EDGE_IRQ_EN
    logic [GPIO_W-1:0] s3_q;
    logic [GPIO_W-1:0] mask_q;
    logic [GPIO_W-1:0] pend_q;
    logic [GPIO_W-1:0] pol_q;
    logic [GPIO_W-1:0] edge_set;
    logic [GPIO_W-1:0] pend_clr;
    logic              irq_q;

    assign edge_set = (s2_q & ~s3_q & pol_q) | (~s2_q & s3_q & ~pol_q);
    assign pend_clr = (wr_en && idx == 3'd3) ? (wbits & wmask) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s3_q   <= '0;
            mask_q <= '0;
            pend_q <= '0;
            pol_q  <= '1;
            irq_q  <= 1'b0;
        end else begin
            s3_q   <= s2_q;
            irq_q  <= |(pend_q & mask_q);
            pend_q <= (pend_q & ~pend_clr) | edge_set;
            if (wr_en && idx == 3'd2)
                mask_q <= (mask_q & ~wmask) | (wbits & wmask);
            if (wr_en && idx == 3'd4)
                pol_q <= (pol_q & ~wmask) | (wbits & wmask);
        end
    end

    assign mask_v = mask_q;
    assign pend_v = pend_q;
    assign pol_v  = pol_q;
    assign irq_v  = irq_q;
`else
    assign mask_v = '0;
    assign pend_v = '0;
    assign pol_v  = '0;
    assign irq_v  = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (idx)
                3'd0: rd_mux = zext(out_q);
                3'd1: rd_mux = zext(s2_q);
                3'd2: rd_mux = zext(mask_v);
                3'd3: rd_mux = zext(pend_v);
                3'd4: rd_mux = zext(pol_v);
                3'd5: begin
                    rd_mux[31]               = code_valid_q;
                    rd_mux[IRQ_NUM_POW-1:0] = code_q;
                end
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_resp_o   <= 1'b0;
            bus_rdata_bo <= '0;
        end else begin
            bus_resp_o   <= rd_en;
            bus_rdata_bo <= rd_en ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_xif_gpio_csr.sv
// Bench for xif_gpio_csr: directed literal checks plus a randomized run against a register-level model.
module tb_xif_gpio_csr;

    localparam int          GW      = 32;
    localparam logic [31:0] BASE    = 32'h80000000;
    localparam logic [31:0] OUT_RST = 32'h000000A5;
`ifdef XIF_GPIO_CSR_EDGE_IRQ_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [31:0] bus_addr_bi;
    logic [3:0]  bus_be_bi;
    logic [31:0] bus_wdata_bi;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic [31:0] gpio_bi;
    logic [31:0] gpio_bo;
    logic [3:0]  irq_code_i;
    logic        irq_ack_i;
    logic        irq_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_out, m_mask, m_pend, m_pol, m_rdata;
    logic [3:0]  m_code;
    logic        m_valid, m_resp, m_irq;
    logic [31:0] pin_hist [3];
    bit          model_ok = 1'b0;

    xif_gpio_csr #(
        .BASE_ADDR  (BASE),
        .GPIO_W     (GW),
        .OUT_RESET  (OUT_RST),
        .IRQ_NUM_POW(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus_req_i   (bus_req_i),
        .bus_we_i    (bus_we_i),
        .bus_addr_bi (bus_addr_bi),
        .bus_be_bi   (bus_be_bi),
        .bus_wdata_bi(bus_wdata_bi),
        .bus_ack_o   (bus_ack_o),
        .bus_resp_o  (bus_resp_o),
        .bus_rdata_bo(bus_rdata_bo),
        .gpio_bi     (gpio_bi),
        .gpio_bo     (gpio_bo),
        .irq_code_i  (irq_code_i),
        .irq_ack_i   (irq_ack_i),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0: return m_out;
            3'd1: return pin_hist[1];
            3'd2: return EDGE ? m_mask : 32'h0;
            3'd3: return EDGE ? m_pend : 32'h0;
            3'd4: return EDGE ? m_pol : 32'h0;
            3'd5: return {m_valid, 27'h0, m_code};
            default: return 32'h0;
        endcase
    endfunction

    // Advances the register-level model by one clock edge using the inputs the bench drove.
    task automatic modelStep();
        logic [31:0] lanes, data_now, qual, clr;
        logic        hit_now, irq_now;
        if (rst_i) begin
            m_out = OUT_RST; m_mask = '0; m_pend = '0; m_pol = '1;
            m_valid = 1'b0; m_code = '0; m_resp = 1'b0; m_rdata = '0; m_irq = 1'b0;
            for (int i = 0; i < 3; i++) pin_hist[i] = '0;
            model_ok = 1'b1;
            return;
        end
        lanes = '0;
        for (int b = 0; b < 4; b++) if (bus_be_bi[b]) lanes[8*b +: 8] = 8'hFF;
        hit_now  = (bus_addr_bi[31:5] == BASE[31:5]);
        data_now = (bus_req_i && !bus_we_i) ? model_read(bus_addr_bi) : 32'h0;
        irq_now  = EDGE && ((m_pend & m_mask) != 0);
        qual = '0;
        for (int i = 0; i < GW; i++)
            if (pin_hist[1][i] != pin_hist[2][i] && pin_hist[1][i] == m_pol[i]) qual[i] = 1'b1;
        clr = '0;
        if (bus_req_i && bus_we_i && hit_now) begin
            case (bus_addr_bi[4:2])
                3'd0: m_out  = (m_out & ~lanes) | (bus_wdata_bi & lanes);
                3'd2: m_mask = (m_mask & ~lanes) | (bus_wdata_bi & lanes);
                3'd3: clr    = bus_wdata_bi & lanes;
                3'd4: m_pol  = (m_pol & ~lanes) | (bus_wdata_bi & lanes);
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | qual;
        if (irq_ack_i) begin
            m_valid = 1'b1;
            m_code  = irq_code_i;
        end else if (bus_req_i && !bus_we_i && hit_now && bus_addr_bi[4:2] == 3'd5) begin
            m_valid = 1'b0;
        end
        pin_hist[2] = pin_hist[1];
        pin_hist[1] = pin_hist[0];
        pin_hist[0] = gpio_bi;
        m_resp  = bus_req_i && !bus_we_i;
        m_rdata = data_now;
        m_irq   = irq_now;
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        bus_req_i    = req;
        bus_we_i     = we;
        bus_addr_bi  = addr;
        bus_be_bi    = be;
        bus_wdata_bi = wdata;
        @(posedge clk_i);
        modelStep();
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, be, data);
    endtask

    task automatic busRead(input logic [31:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 4'h0, 32'h0);
    endtask

    always @(negedge clk_i) begin
        if (model_ok) begin
            checkOutput("bus_ack", {31'h0, bus_ack_o}, {31'h0, bus_req_i});
            checkOutput("bus_resp", {31'h0, bus_resp_o}, {31'h0, m_resp});
            checkOutput("bus_rdata", bus_rdata_bo, m_rdata);
            checkOutput("gpio_bo", gpio_bo, m_out);
            checkOutput("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
        end
    end

    initial begin
        rst_i = 1'b1; gpio_bi = '0; irq_ack_i = 1'b0; irq_code_i = '0;
        repeat (3) idle();
        rst_i = 1'b0;
        checkOutput("reset gpio_bo", gpio_bo, 32'hA5);
        checkOutput("reset resp", {31'h0, bus_resp_o}, 32'h0);
        checkOutput("reset irq", {31'h0, irq_o}, 32'h0);
        busRead(BASE + 32'h10);
        checkOutput("reset POL", bus_rdata_bo, EDGE ? 32'hFFFFFFFF : 32'h0);
        idle();
        checkOutput("resp one cycle", {31'h0, bus_resp_o}, 32'h0);

        busWrite(BASE, 4'hF, 32'h0);
        busWrite(BASE, 4'b0101, 32'h12345678);
        checkOutput("OUT lanes pin", gpio_bo, 32'h00340078);
        busRead(BASE);
        checkOutput("OUT lanes resp", {31'h0, bus_resp_o}, 32'h1);
        checkOutput("OUT lanes read", bus_rdata_bo, 32'h00340078);
        busWrite(BASE, 4'h0, 32'hFFFFFFFF);
        checkOutput("be zero write", gpio_bo, 32'h00340078);

        busRead(BASE + 32'h18);
        checkOutput("0x18 resp", {31'h0, bus_resp_o}, 32'h1);
        checkOutput("0x18 data", bus_rdata_bo, 32'h0);
        busRead(32'h90000000);
        checkOutput("miss resp", {31'h0, bus_resp_o}, 32'h1);
        checkOutput("miss data", bus_rdata_bo, 32'h0);
        idle();

        busWrite(BASE + 32'h08, 4'hF, 32'h1);
        gpio_bi = 32'h1;
        repeat (3) idle();
        checkOutput("irq before edge+4", {31'h0, irq_o}, 32'h0);
        busRead(BASE + 32'h0C);
        checkOutput("PEND set", bus_rdata_bo, EDGE ? 32'h1 : 32'h0);
        checkOutput("irq at edge+4", {31'h0, irq_o}, {31'h0, EDGE});
        busWrite(BASE + 32'h0C, 4'hF, 32'h1);
        idle();
        checkOutput("irq after W1C", {31'h0, irq_o}, 32'h0);

        gpio_bi = 32'h0;
        repeat (4) idle();
        gpio_bi = 32'h1;
        repeat (2) idle();
        busWrite(BASE + 32'h0C, 4'hF, 32'h1);
        busRead(BASE + 32'h0C);
        checkOutput("set beats W1C", bus_rdata_bo, EDGE ? 32'h1 : 32'h0);
        busWrite(BASE + 32'h0C, 4'hF, 32'h1);
        busRead(BASE + 32'h0C);
        checkOutput("PEND cleared", bus_rdata_bo, 32'h0);

        irq_code_i = 4'h3; irq_ack_i = 1'b1;
        idle();
        irq_ack_i = 1'b0;
        busRead(BASE + 32'h14);
        checkOutput("IRQCODE valid", bus_rdata_bo, 32'h80000003);
        irq_code_i = 4'h5; irq_ack_i = 1'b1;
        busRead(BASE + 32'h14);
        checkOutput("IRQCODE cleared", bus_rdata_bo, 32'h00000003);
        irq_ack_i = 1'b0;
        busRead(BASE + 32'h14);
        checkOutput("ack beats clear", bus_rdata_bo, 32'h80000005);

        gpio_bi = 32'hDEADBEEF;
        busRead(BASE + 32'h04);
        checkOutput("IN old 1", bus_rdata_bo, 32'h1);
        busRead(BASE + 32'h04);
        checkOutput("IN old 2", bus_rdata_bo, 32'h1);
        busRead(BASE + 32'h04);
        checkOutput("IN new", bus_rdata_bo, 32'hDEADBEEF);

        busWrite(BASE + 32'h08, 4'hF, 32'hFFFFFFFF);
        busRead(BASE + 32'h08);
        checkOutput("MASK all ones", bus_rdata_bo, EDGE ? 32'hFFFFFFFF : 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] addr;
            rst_i = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) gpio_bi = $urandom;
            else if ($urandom_range(0, 2) == 0) gpio_bi = gpio_bi ^ (32'h1 << $urandom_range(0, 31));
            irq_ack_i  = ($urandom_range(0, 9) == 0);
            irq_code_i = 4'($urandom_range(0, 15));
            addr = ($urandom_range(0, 3) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 31)));
            applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, addr,
                          4'($urandom_range(0, 15)), $urandom);
        end
        rst_i = 1'b0; irq_ack_i = 1'b0;
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xif_gpio_csr.md
# xif_gpio_csr

Parametrised memory-mapped GPIO/CSR peripheral for the tile's external (xif) split bus. Provides a byte-enabled output register, a synchronised input register, an interrupt-code capture register and, optionally, per-bit edge-detect interrupts. It replaces ad-hoc LED/switch decode logic at the SoC top level with a reusable block that answers every read it accepts.

## Interface
- `BASE_ADDR`, 32'h80000000. 32-byte aligned register window base.
- `GPIO_W`, 32. GPIO width in bits, 1..32.
- `OUT_RESET`, 0. Reset value of the OUT register (`GPIO_W` bits).
- `IRQ_NUM_POW`, 4. Width of the CPU IRQ code.
- `clk_i` in 1. Single clock.
- `rst_i` in 1. Reset, synchronous, active-high.
- `bus_req_i` in 1. Request.
- `bus_we_i` in 1. 1 = write.
- `bus_addr_bi` in 32. Byte address.
- `bus_be_bi` in 4. Byte enables (writes only).
- `bus_wdata_bi` in 32. Write data.
- `bus_ack_o` out 1. Request accepted.
- `bus_resp_o` out 1. Read response valid.
- `bus_rdata_bo` out 32. Read data.
- `gpio_bi` in GPIO_W. Asynchronous inputs.
- `gpio_bo` out GPIO_W. OUT register.
- `irq_code_i` in IRQ_NUM_POW. CPU IRQ code.
- `irq_ack_i` in 1. CPU IRQ acknowledge strobe.
- `irq_o` out 1. Level interrupt request.

## Operation
- Hit: `bus_addr_bi[31:5] == BASE_ADDR[31:5]`. Register index = `addr[4:2]`; `addr[1:0]` ignored.
- Register map (offset, access):
  - 0x00 OUT, RW.
  - 0x04 IN, RO; returns the synced value.
  - 0x08 IRQ_MASK, RW.
  - 0x0C IRQ_PEND, RW1C.
  - 0x10 EDGE_POL, RW; 1 = rising, 0 = falling. Resets to all ones.
  - 0x14 IRQCODE, RO; bit 31 is a valid flag, bits [IRQ_NUM_POW-1:0] hold the last code.
  - 0x18 and 0x1C: reads return 0, writes are ignored.
- Bits above `GPIO_W` read 0 and ignore writes.
- Writes apply per byte lane where `bus_be_bi[n]` = 1. A write with `be` = 0 is accepted but has no effect.
- Non-hit requests are still acked. Non-hit reads get a response with rdata 0. Non-hit writes are dropped.
- Input path: 2-flop synchroniser (s1, s2), then a third flop s3 for edge detection.
  - Rising edge: s2 & ~s3.
  - Falling edge: ~s2 & s3.
  - POL selects the edge type per bit.
- PEND bit sets on a qualifying edge regardless of MASK. Writing 1 clears it.
- Set and W1C on the same bit in the same cycle: set wins.
- `irq_ack_i` = 1: IRQCODE <= {1'b1, zero-pad, `irq_code_i`}. Reading IRQCODE clears the valid flag.
- `irq_ack_i` in the same cycle as an IRQCODE read: the new code is captured and valid stays 1.

## Timing
- `bus_ack_o = bus_req_i`, combinational, with no wait states. The block accepts one request per cycle, back-to-back.
- Read accepted in cycle N: `bus_resp_o` = 1 in cycle N+1 only. `bus_rdata_bo` is valid in N+1 and is 0 whenever `bus_resp_o` = 0.
- Read data reflects register state at the end of cycle N.
- Writes generate no response. A write in cycle N is visible on `gpio_bo` in N+1 and to a read accepted in N+1.
- Pin-to-IN latency: a `gpio_bi` change sampled at edge k appears in IN at edge k+2. PEND sets at edge k+3; `irq_o` asserts at edge k+4.
- `irq_o` is registered: `irq_o <= |(PEND & MASK)`. It deasserts 1 cycle after the clearing write or mask write.
- Reset values (on `rst_i` = 1 at a clock edge):
  - `gpio_bo` = OUT_RESET.
  - MASK = 0, PEND = 0, POL = all ones.
  - IRQCODE = 0.
  - `bus_resp_o`, `bus_rdata_bo`, `irq_o` = 0.
  - Synchroniser flops = 0.
- Reset mid-read: the pending response is dropped; no resp is issued after reset.
- First cycle after reset: s3 = 0, so inputs held high produce a rising edge 3 cycles after reset release. Software clears PEND before unmasking.

## Configuration
- Macro `XIF_GPIO_CSR_EDGE_IRQ_EN`.
- Defined: the edge detector, MASK, PEND, POL and `irq_o` are implemented as described above.
- Undefined:
  - The s3 flop and edge logic are not built.
  - MASK/PEND/POL read 0 and ignore writes.
  - `irq_o` is tied to 0.
  - OUT, IN and IRQCODE are unchanged.

## Test plan
- Reset with OUT_RESET=32'hA5 -> `gpio_bo`=32'hA5, POL reads 32'hFFFFFFFF, `bus_resp_o`=0, `irq_o`=0.
- Write 32'h12345678 with be=4'b0101 to 0x80000000 over initial OUT 0, then read -> resp exactly 1 cycle after the read; rdata=32'h00340078.
- Read 0x80000018, then read 0x90000000 back-to-back -> two single-cycle responses, both rdata=0, acks in both cycles.
- MASK=1, POL bit0=1, `gpio_bi[0]` 0->1 -> PEND=1 and `irq_o`=1 at edge+4. W1C 0x0C=1 -> `irq_o`=0 next cycle. A new edge coinciding with the W1C leaves PEND=1.
- `irq_ack_i` pulse with code 4'h3, then read 0x14 -> rdata=32'h80000003; second read -> 32'h00000003.
- Macro undefined: toggle `gpio_bi`, write 0x08=all ones -> `irq_o` stays 0, 0x08/0x0C read 0, IN tracks pins with 2-cycle latency.
